// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus per-bit stability-counter debouncer for the board switches,
// with sticky per-bit change flags that a single chg_clr pulse clears.
module switch_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             chg_clr,
    output logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] changed,
    output logic             any_change
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] switches_nxt;
    logic [WIDTH-1:0] set_v;
    logic [WIDTH-1:0] changed_nxt;

    // NOTE: every signal gets a default before any branch, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        switches_nxt = switches;
        set_v        = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != switches[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    switches_nxt[i] = sync2[i];
                    set_v[i]        = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
        // A new event wins over a simultaneous clear so it is never lost.
        changed_nxt = (changed & ~{WIDTH{chg_clr}}) | set_v;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples the
    // pre-edge values; the counter array is reset too, so a reset discards any
    // partial count instead of resuming it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            switches   <= '0;
            changed    <= '0;
            any_change <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1      <= sw_raw;
            sync2      <= sync1;
            switches   <= switches_nxt;
            changed    <= changed_nxt;
            any_change <= |changed_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule
